move_table_display: RTL
=======================

MOVE_TABLE_DISPLAY -- requirements
Module: move_table_display

Parameters
REQ-001 SHALL have parameter EVAL_WIDTH, default 0, signed evaluation width.
REQ-002 SHALL have parameter HALF_MOVE_WIDTH, default 0, half-move counter width.
REQ-003 SHALL have parameter UCI_WIDTH, default 0, packed UCI move width.
REQ-004 SHALL have parameter MAX_MOVES, default 64, move-table depth; AW = $clog2(MAX_MOVES), CW = $clog2(MAX_MOVES+1).

Interface
REQ-005 SHALL have: clk  in  1  sole clock; all logic on posedge.
REQ-006 SHALL have: reset  in  1  synchronous, active-low (0 = reset).
REQ-007 SHALL have: start  in  1  one-cycle request to walk the table.
REQ-008 SHALL have: move_count  in  CW  entries to walk, from index 0.
REQ-009 SHALL have: pv_only  in  1  display only entries whose pv bit is 1.
REQ-010 SHALL have: abort  in  1  stop the walk early.
REQ-011 SHALL have: rd_en  out  1  table read strobe; rd_addr  out  AW  table index.
REQ-012 SHALL have: rd_entry  in  `BOARD_WIDTH+14+EVAL_WIDTH+HALF_MOVE_WIDTH+UCI_WIDTH; packed MSB->LSB {board, castle_mask[3:0], en_passant_col[3:0], capture, pv, white_in_check, black_in_check, eval, thrice_rep, half_move, uci}.
REQ-013 SHALL have registered outputs board, castle_mask, en_passant_col, capture, pv, white_in_check, black_in_check, eval (signed), thrice_rep, half_move, uci, with widths as in REQ-012, feeding the display stage.
REQ-014 SHALL have: display  out  1  one-cycle request to the display stage; display_done  in  1  display-stage completion pulse.
REQ-015 SHALL have: busy  out  1; done  out  1  one-cycle completion pulse; shown_count  out  CW  entries displayed in the last walk.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT_RD, CAPTURE, SHOW, WAIT_DONE, NEXT, FINISH.
REQ-017 SHALL accept start only in IDLE: latch min(move_count, MAX_MOVES) and pv_only, clear index and shown_count, set busy, go to FETCH; start in any other state SHALL be ignored.
REQ-018 SHALL go from IDLE directly to FINISH when the latched count is 0, issuing no read and no display.
REQ-019 FETCH SHALL assert rd_en for exactly one cycle with rd_addr = index; rd_entry is valid the cycle after rd_en (WAIT_RD).
REQ-020 CAPTURE SHALL register every rd_entry field into its output; outputs SHALL then hold stable until the next CAPTURE.
REQ-021 CAPTURE SHALL go to NEXT without displaying when pv_only is latched and the captured pv is 0; otherwise it SHALL go to SHOW.
REQ-022 SHOW SHALL assert display for exactly one cycle, then go to WAIT_DONE.
REQ-023 WAIT_DONE SHALL wait, with no timeout, for display_done = 1, which SHALL be sampled in no other state.
REQ-024 On display_done = 1, shown_count SHALL increment by 1.
REQ-025 NEXT SHALL increment index; if the new index equals the latched count it SHALL go to FINISH, otherwise to FETCH.
REQ-026 FINISH SHALL pulse done for one cycle, clear busy and return to IDLE; shown_count SHALL hold until the next accepted start.
REQ-027 abort in FETCH, WAIT_RD, CAPTURE, SHOW or NEXT SHALL force FINISH on the next cycle; display SHALL NOT assert if aborted in SHOW.
REQ-028 abort in WAIT_DONE SHALL set a pending flag; the current handshake completes (shown_count increments), then FINISH is entered.
REQ-029 abort in IDLE or FINISH SHALL be ignored; start with abort in IDLE SHALL start the walk.
REQ-030 Minimum per-entry latency SHALL be FETCH+WAIT_RD+CAPTURE+SHOW = 4 cycles before WAIT_DONE.

Reset
REQ-031 reset = 0 at a clock edge SHALL force IDLE and clear busy, done, display, rd_en, rd_addr, index, shown_count, the pending abort, and all REQ-013 outputs to 0.
REQ-032 reset mid-walk SHALL abandon the walk without a done pulse; the display stage is reset by the same signal.

Verification
REQ-033 move_count=3, pv_only=0, display-stage model returns display_done 5 cycles after display -> rd_addr 0,1,2 in order, 3 single-cycle display pulses, outputs equal each entry, done once, shown_count=3.
REQ-034 move_count=0 -> no rd_en, no display, done 1 cycle after start, shown_count=0.
REQ-035 pv_only=1, table pv bits {1,0,1,0} with move_count=4 -> 4 reads, 2 displays (entries 0 and 2), shown_count=2.
REQ-036 abort asserted in WAIT_DONE of entry 1 of 4 -> entry 1 completes, no read of index 2, done pulse, shown_count=2.
REQ-037 move_count=MAX_MOVES+5 -> exactly MAX_MOVES reads; start pulsed while busy -> ignored, no walk restart.
REQ-038 reset=0 in SHOW -> next cycle display=0, busy=0, all outputs 0, no done; new start then walks from index 0.

Source files
------------

// File: rtl/move_table_display.sv
// rtl/move_table_display.sv - walks a move table and hands each entry to a display stage
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module move_table_display #(
  parameter int EVAL_WIDTH      = 0,
  parameter int HALF_MOVE_WIDTH = 0,
  parameter int UCI_WIDTH       = 0,
  parameter int MAX_MOVES       = 64,
  localparam int AW    = $clog2(MAX_MOVES),
  localparam int CW    = $clog2(MAX_MOVES + 1),
  localparam int BW    = `BOARD_WIDTH,
  // a zero field width is carried as one bit so every slice stays legal
  localparam int EW    = (EVAL_WIDTH > 0) ? EVAL_WIDTH : 1,
  localparam int HW    = (HALF_MOVE_WIDTH > 0) ? HALF_MOVE_WIDTH : 1,
  localparam int UW    = (UCI_WIDTH > 0) ? UCI_WIDTH : 1,
  localparam int ENT_W = BW + 14 + EW + HW + UW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CW-1:0]        move_count,
  input  logic                 pv_only,
  input  logic                 abort,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [ENT_W-1:0]     rd_entry,
  output logic [BW-1:0]        board,
  output logic [3:0]           castle_mask,
  output logic [3:0]           en_passant_col,
  output logic                 capture,
  output logic                 pv,
  output logic                 white_in_check,
  output logic                 black_in_check,
  output logic signed [EW-1:0] eval,
  output logic                 thrice_rep,
  output logic [HW-1:0]        half_move,
  output logic [UW-1:0]        uci,
  output logic                 display,
  input  logic                 display_done,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        shown_count
);

  localparam int P_HM  = UW;
  localparam int P_TR  = UW + HW;
  localparam int P_EV  = P_TR + 1;
  localparam int P_BIC = P_EV + EW;
  localparam int P_WIC = P_BIC + 1;
  localparam int P_PV  = P_BIC + 2;
  localparam int P_CAP = P_BIC + 3;
  localparam int P_EP  = P_BIC + 4;
  localparam int P_CM  = P_BIC + 8;
  localparam int P_BD  = P_BIC + 12;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_RD, CAPTURE, SHOW, WAIT_DONE, NEXT, FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    shown_q, shown_d;
  logic [AW-1:0]    index_q, index_d;
  logic             pv_only_q, pv_only_d;
  logic             abort_pend_q, abort_pend_d;
  logic [ENT_W-2:0] entry_q;
  logic [CW-1:0]    limit;
  logic [CW-1:0]    index_nx;
  logic             unused_spare;

  // the entry carries one more bit than its fields; the top bit is not used
  assign unused_spare = rd_entry[ENT_W-1];

  assign limit    = (move_count > CW'(MAX_MOVES)) ? CW'(MAX_MOVES) : move_count;
  assign index_nx = CW'(index_q) + CW'(1);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shown_d      = shown_q;
    index_d      = index_q;
    pv_only_d    = pv_only_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d      = limit;
          pv_only_d    = pv_only;
          index_d      = '0;
          shown_d      = '0;
          abort_pend_d = 1'b0;
          state_d      = (limit == '0) ? FINISH : FETCH;
        end
      end
      FETCH:   state_d = abort ? FINISH : WAIT_RD;
      WAIT_RD: state_d = abort ? FINISH : CAPTURE;
      CAPTURE: begin
        if (abort)                            state_d = FINISH;
        else if (pv_only_q && !entry_q[P_PV]) state_d = NEXT;
        else                                  state_d = SHOW;
      end
      SHOW:    state_d = abort ? FINISH : WAIT_DONE;
      WAIT_DONE: begin
        // an abort here only takes effect once the display handshake closes
        if (abort) abort_pend_d = 1'b1;
        if (display_done) begin
          shown_d = shown_q + CW'(1);
          state_d = (abort_pend_q || abort) ? FINISH : NEXT;
        end
      end
      NEXT: begin
        index_d = AW'(index_nx);
        state_d = (abort || index_nx == count_q) ? FINISH : FETCH;
      end
      FINISH: begin
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shown_q      <= '0;
      index_q      <= '0;
      pv_only_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      entry_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shown_q      <= shown_d;
      index_q      <= index_d;
      pv_only_q    <= pv_only_d;
      abort_pend_q <= abort_pend_d;
      if (state_d == CAPTURE) entry_q <= rd_entry[ENT_W-2:0];
    end
  end

  assign rd_en       = (state_q == FETCH);
  assign rd_addr     = index_q;
  assign display     = (state_q == SHOW) && !abort;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign shown_count = shown_q;

  assign board          = entry_q[P_BD +: BW];
  assign castle_mask    = entry_q[P_CM +: 4];
  assign en_passant_col = entry_q[P_EP +: 4];
  assign capture        = entry_q[P_CAP];
  assign pv             = entry_q[P_PV];
  assign white_in_check = entry_q[P_WIC];
  assign black_in_check = entry_q[P_BIC];
  assign eval           = entry_q[P_EV +: EW];
  assign thrice_rep     = entry_q[P_TR];
  assign half_move      = entry_q[P_HM +: HW];
  assign uci            = entry_q[0 +: UW];

endmodule
